// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: PC-source encodings, NOP encoding,
// fetch FSM states and the IF skid-buffer bundle.
package cpu_pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    // sll r0,r0,0
    localparam logic [31:0] NOP_ENC = 32'h0000_0000;

    typedef enum logic {
        F_REQ,
        F_FULL
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fetch_buf_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection for the fetch stage: redirect target select and
// priority between same-cycle redirect, pending redirect and pc+4.
module if_next_pc
    import cpu_pipe_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        redir_v,
    input  logic [31:0] redir_pc,
    input  logic        redirect_now,
    output logic [31:0] pc4,
    output logic [31:0] target,
    output logic [31:0] npc
);

    assign pc4 = pc + 32'd4;

    always_comb begin
        target = pc4;
        unique case (1'b1)
            (pcsource == PCSRC_SEQ): target = pc4;
            (pcsource == PCSRC_BR):  target = word_align(bpc);
            (pcsource == PCSRC_JR):  target = word_align(rpc);
            (pcsource == PCSRC_J):   target = word_align(jpc);
        endcase
    end

    // Same-cycle redirect wins so the delay slot completing now is bypassed
    always_comb begin
        npc = pc4;
        if (redirect_now)
            npc = target;
        else if (redir_v)
            npc = redir_pc;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with one-entry skid buffer and delay-slot redirect.
// Optional IF_PERF_EN adds saturating fetch/stall counters.
module if_stage
    import cpu_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_ENC
)(
    input  logic        clock,
    input  logic        resetn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_inst,
    output logic [31:0] pc,
    output logic [31:0] d_inst,
    output logic [31:0] d_pc4,
    output logic        d_valid
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
`endif
);

    fetch_state_t state, state_nx;
    fetch_buf_t   fbuf, fbuf_nx;

    logic [31:0] pc_nx, d_inst_nx, d_pc4_nx;
    logic        d_valid_nx;
    logic        redir_v, redir_v_nx;
    logic [31:0] redir_pc, redir_pc_nx;
    logic [31:0] pc4, target, npc;
    logic        redirect_now;

    assign redirect_now = d_valid & wpcir & (pcsource != PCSRC_SEQ);
    assign imem_addr    = pc;

    if_next_pc u_next_pc (
        .pc           (pc),
        .pcsource     (pcsource),
        .bpc          (bpc),
        .rpc          (rpc),
        .jpc          (jpc),
        .redir_v      (redir_v),
        .redir_pc     (redir_pc),
        .redirect_now (redirect_now),
        .pc4          (pc4),
        .target       (target),
        .npc          (npc)
    );

    always_comb begin
        state_nx    = state;
        fbuf_nx     = fbuf;
        pc_nx       = pc;
        d_inst_nx   = d_inst;
        d_pc4_nx    = d_pc4;
        d_valid_nx  = d_valid;
        redir_v_nx  = redir_v;
        redir_pc_nx = redir_pc;
        imem_req    = 1'b0;
        unique case (state)
            F_REQ: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    pc_nx      = npc;
                    redir_v_nx = 1'b0;
                    if (wpcir) begin
                        d_inst_nx  = imem_inst;
                        d_pc4_nx   = pc4;
                        d_valid_nx = 1'b1;
                    end else begin
                        fbuf_nx  = '{inst: imem_inst, pc4: pc4};
                        state_nx = F_FULL;
                    end
                end else if (wpcir) begin
                    d_inst_nx  = NOP_INST;
                    d_valid_nx = 1'b0;
                    // Delay slot still in flight: remember where to go after it
                    if (redirect_now) begin
                        redir_v_nx  = 1'b1;
                        redir_pc_nx = target;
                    end
                end
            end
            F_FULL: begin
                if (wpcir) begin
                    d_inst_nx  = fbuf.inst;
                    d_pc4_nx   = fbuf.pc4;
                    d_valid_nx = 1'b1;
                    state_nx   = F_REQ;
                    // Delay slot already buffered, so pc moves straight to target
                    if (redirect_now)
                        pc_nx = target;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= F_REQ;
            fbuf     <= '0;
            pc       <= RESET_PC;
            d_inst   <= NOP_INST;
            d_pc4    <= '0;
            d_valid  <= 1'b0;
            redir_v  <= 1'b0;
            redir_pc <= '0;
        end else begin
            state    <= state_nx;
            fbuf     <= fbuf_nx;
            pc       <= pc_nx;
            d_inst   <= d_inst_nx;
            d_pc4    <= d_pc4_nx;
            d_valid  <= d_valid_nx;
            redir_v  <= redir_v_nx;
            redir_pc <= redir_pc_nx;
        end
    end

`ifdef IF_PERF_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (state == F_REQ && imem_rdy && perf_fetch != 32'hFFFF_FFFF)
                perf_fetch <= perf_fetch + 32'd1;
            if (d_valid && !wpcir && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of the decode/control stage.
- Holds the PC and issues fetches to instruction memory over a variable-latency req/rdy handshake.
- Applies decode's stall (wpcir) and redirect (pcsource) with architected one-instruction branch delay slot.
- Drives the IF/ID pipeline register (instruction, PC+4, valid).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction injected into ID as a bubble (sll r0,r0,0)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
wpcir  input  1  from decode: 1 = ID instruction advances this cycle, 0 = stall PC and IF/ID
pcsource  input  2  from decode: 00 pc+4, 01 branch (bpc), 10 register jump (rpc), 11 jump (jpc)
bpc  input  32  branch target from decode
rpc  input  32  jr target (forwarded rs value)
jpc  input  32  j/jal target
imem_req  output  1  fetch request, held until imem_rdy
imem_addr  output  32  fetch address (= pc)
imem_rdy  input  1  instruction data valid this cycle
imem_inst  input  32  fetched instruction
pc  output  32  current fetch PC
d_inst  output  32  IF/ID instruction
d_pc4  output  32  IF/ID PC+4 of d_inst
d_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, resetn=0): pc=RESET_PC, d_inst=NOP_INST, d_pc4=0, d_valid=0, state=F_REQ, redir_v=0, redir_pc=0, buf cleared. Any outstanding fetch is abandoned; imem_rdy during reset ignored.
- ID consumes when wpcir=1; redirect is taken only when d_valid=1 & wpcir=1 & pcsource!=00. Decode inputs are ignored when d_valid=0.
- Target select: 01→bpc, 10→rpc, 11→jpc; bits [1:0] of every target forced to 0.
- FSM:
  - F_REQ: imem_req=1, imem_addr=pc.
    - imem_rdy & wpcir: IF/ID ← {imem_inst, pc+4, 1}; pc←npc; stay.
    - imem_rdy & ~wpcir: buf←{imem_inst, pc+4}; pc←npc; →F_FULL.
    - ~imem_rdy & wpcir: IF/ID ← {NOP_INST, d_pc4, 0} (bubble).
    - ~imem_rdy & ~wpcir: IF/ID held.
  - F_FULL: imem_req=0, IF/ID held while ~wpcir. On wpcir: IF/ID←{buf,1}; →F_REQ.
- npc: priority is (1) redirect taken this same cycle, (2) redir_pc when redir_v=1, (3) pc+4. Case (1) is the bypass for the delay slot completing in the branch's consume cycle. redir_v clears when npc is consumed.
- Delay slot: the instruction at branch_pc+4 always issues. The target is fetched next.
- Redirect captured into redir_pc/redir_v when taken and no fetch completes that cycle. If the delay slot is already in buf, pc already equals branch_pc+8: pc←target immediately, redir_v stays 0.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- A new request is issued only after the previous rdy; at most one outstanding fetch.
- imem_rdy seen while imem_req=0 is ignored.

Optional Feature:
- Macro: IF_PERF_EN.
- Defined: adds outputs perf_fetch[31:0] (count of imem_rdy accepted) and perf_stall[31:0] (cycles with d_valid=1 & wpcir=0). Both reset to 0, saturate at 32'hFFFF_FFFF.
- Undefined: no such ports or logic; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pipe_pkg:
  - PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JR=2'b10, PCSRC_J=2'b11
  - NOP encoding
  - fetch state enum {F_REQ, F_FULL}
- Sub-module: if_next_pc. Combinational target select and npc priority (inputs pc, pcsource, bpc, rpc, jpc, redir_v, redir_pc, redirect_now).

Test Plan:
- Reset, then imem_rdy every cycle, wpcir=1 → imem_addr 0,4,8,…; d_inst follows memory with 1-cycle latency; d_pc4=addr+4; d_valid=1 from second cycle.
- imem_rdy every 3rd cycle, wpcir=1 → exactly two NOP bubbles (d_valid=0) between real instructions; no address skipped.
- wpcir=0 for 4 cycles while fetch returns → F_FULL; imem_req=0; IF/ID frozen. On wpcir=1, buffered instruction enters IF/ID with correct d_pc4, and fetch resumes at next address.
- Branch at 0x10, pcsource=01, bpc=0x40, delay-slot fetch latency 2 → delay slot 0x14 reaches ID, next imem_addr=0x40, never 0x18.
- jr with rpc=0x103 when delay slot rdy in the same cycle → next imem_addr=0x100 (bypass path, low bits cleared).
- resetn asserted while imem_req=1 and F_FULL → outputs immediately at reset values; first fetch after release at RESET_PC.
